// File: rtl/mux4_rr_arbiter.sv
// Four-source round-robin arbiter driving a 4:1 data mux.
// An owner is preempted after HOLD_CYCLES cycles if another source is waiting.
module mux4_rr_arbiter #(
  parameter int HOLD_CYCLES = 4,
  parameter int DW          = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    req,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [DW-1:0] c,
  input  logic [DW-1:0] d,
  output logic [3:0]    gnt,
  output logic          sel1,
  output logic          sel2,
  output logic          busy,
  output logic [DW-1:0] y
);

  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 15) begin : g_bad_hold
    $error("HOLD_CYCLES must be in 1..15");
  end

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [3:0] CNT_LAST = 4'(HOLD_CYCLES - 1);

  state_t     state_reg, state_next;
  logic [3:0] gnt_reg, gnt_next;
  logic [1:0] sel_reg, sel_next;
  logic [1:0] ptr_reg, ptr_next;
  logic [3:0] cnt_reg, cnt_next;
  logic       busy_reg, busy_next;

  logic [3:0] cand;
  logic [3:0] rot;
  logic [1:0] off;
  logic [1:0] pick;
  logic       found;
  logic       do_grant;

  // While busy the current owner is never a candidate, so a switch always lands elsewhere.
  assign cand = (state_reg == IDLE) ? req : (req & ~gnt_reg);

  // rot[k] is the candidate k places after ptr in search order.
  for (genvar gi = 0; gi < 4; gi++) begin : g_rot
    assign rot[gi] = cand[ptr_reg + 2'(gi)];
  end

  always_comb begin
    off = 2'd0;
    if (rot[0])      off = 2'd0;
    else if (rot[1]) off = 2'd1;
    else if (rot[2]) off = 2'd2;
    else if (rot[3]) off = 2'd3;
  end

  assign found = |rot;
  assign pick  = ptr_reg + off;

  always_comb begin
    state_next = state_reg;
    gnt_next   = gnt_reg;
    sel_next   = sel_reg;
    ptr_next   = ptr_reg;
    cnt_next   = cnt_reg;
    do_grant   = 1'b0;

    case (state_reg)
      IDLE: begin
        gnt_next = 4'b0000;
        if (found) do_grant = 1'b1;
      end
      BUSY: begin
        if ((req & gnt_reg) == 4'b0000) begin
          if (found) begin
            do_grant = 1'b1;
          end else begin
            state_next = IDLE;
            gnt_next   = 4'b0000;
            cnt_next   = 4'd0;
          end
        end else if (cnt_reg == CNT_LAST) begin
          if (found) do_grant = 1'b1;
          else       cnt_next = 4'd0;
        end else begin
          cnt_next = cnt_reg + 4'd1;
        end
      end
      default: begin
        state_next = IDLE;
        gnt_next   = 4'b0000;
      end
    endcase

    if (do_grant) begin
      state_next = BUSY;
      gnt_next   = 4'b0001 << pick;
      sel_next   = pick;
      ptr_next   = pick + 2'd1;
      cnt_next   = 4'd0;
    end

    busy_next = (state_next == BUSY);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      gnt_reg   <= 4'b0000;
      sel_reg   <= 2'b00;
      ptr_reg   <= 2'b00;
      cnt_reg   <= 4'd0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      gnt_reg   <= gnt_next;
      sel_reg   <= sel_next;
      ptr_reg   <= ptr_next;
      cnt_reg   <= cnt_next;
      busy_reg  <= busy_next;
    end
  end

  assign gnt  = gnt_reg;
  assign sel1 = sel_reg[0];
  assign sel2 = sel_reg[1];
  assign busy = busy_reg;

  always_comb begin
    y = '0;
    if (busy_reg) begin
      case (sel_reg)
        2'd0:    y = a;
        2'd1:    y = b;
        2'd2:    y = c;
        default: y = d;
      endcase
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench: two arbiters (hold 4 and hold 1) share stimulus; a queue-based
// reference model predicts each cycle and an independent monitor compares.
module tb_mux4_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [7:0] a = 8'h00, b = 8'h00, c = 8'h00, d = 8'h00;

  logic [3:0] gnt4, gnt1;
  logic       sel1_4, sel2_4, busy4, sel1_1, sel2_1, busy1;
  logic [7:0] y4, y1;

  always #5 clk = ~clk;

  mux4_rr_arbiter #(.HOLD_CYCLES(4), .DW(8)) dut4 (
    .clk(clk), .rst(rst), .req(req), .a(a), .b(b), .c(c), .d(d),
    .gnt(gnt4), .sel1(sel1_4), .sel2(sel2_4), .busy(busy4), .y(y4)
  );

  mux4_rr_arbiter #(.HOLD_CYCLES(1), .DW(8)) dut1 (
    .clk(clk), .rst(rst), .req(req), .a(a), .b(b), .c(c), .d(d),
    .gnt(gnt1), .sel1(sel1_1), .sel2(sel2_1), .busy(busy1), .y(y1)
  );

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
  } exp_t;

  exp_t q4[$];
  exp_t q1[$];

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: owner (-1 = none), priority pointer, cycles owned so far.
  int owner[2];
  int ptr[2];
  int held[2];
  int lsel[2];
  int hold_of[2];
  int wait4[4];
  int wait1[4];

  function automatic int first_from(int p, logic [3:0] m);
    for (int k = 0; k < 4; k++) begin
      if (m[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      owner[k] = -1;
      ptr[k]   = 0;
      held[k]  = 0;
      lsel[k]  = 0;
    end
    for (int i = 0; i < 4; i++) begin
      wait4[i] = 0;
      wait1[i] = 0;
    end
  endtask

  task automatic model_step(input int k, input logic [3:0] r, output exp_t e);
    logic [3:0] others;
    int nxt;
    nxt = -2;
    if (owner[k] < 0) begin
      if (r != 4'b0000) nxt = first_from(ptr[k], r);
    end else begin
      others = r;
      others[owner[k]] = 1'b0;
      if (!r[owner[k]]) begin
        if (others != 4'b0000) nxt = first_from(ptr[k], others);
        else owner[k] = -1;
      end else if (held[k] == hold_of[k]) begin
        if (others != 4'b0000) nxt = first_from(ptr[k], others);
        else held[k] = 1;
      end else begin
        held[k] = held[k] + 1;
      end
    end
    if (nxt >= 0) begin
      owner[k] = nxt;
      ptr[k]   = (nxt + 1) % 4;
      held[k]  = 1;
    end
    if (owner[k] >= 0) lsel[k] = owner[k];
    e.gnt  = (owner[k] >= 0) ? (4'b0001 << owner[k]) : 4'b0000;
    e.sel  = 2'(lsel[k]);
    e.busy = (owner[k] >= 0);
  endtask

  function automatic logic [7:0] data_of(input logic [1:0] s, input logic bz);
    if (!bz) return 8'h00;
    case (s)
      2'd0:    return a;
      2'd1:    return b;
      2'd2:    return c;
      default: return d;
    endcase
  endfunction

  task automatic check(input string name, input exp_t e, input logic [3:0] g,
                       input logic s1, input logic s2, input logic bz, input logic [7:0] yy);
    logic [7:0] ey;
    ey = data_of(e.sel, e.busy);
    vectors++;
    if (g !== e.gnt || {s2, s1} !== e.sel || bz !== e.busy || yy !== ey) begin
      miscompares++;
      $display("FAIL %s t=%0t: gnt=%b sel=%b busy=%b y=%h, expected gnt=%b sel=%b busy=%b y=%h",
               name, $time, g, {s2, s1}, bz, yy, e.gnt, e.sel, e.busy, ey);
    end
  endtask

  // Monitor: one expected response per clock, checked just after the edge.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (q4.size() > 0) begin
      e = q4.pop_front();
      check("hold4", e, gnt4, sel1_4, sel2_4, busy4, y4);
      for (int i = 0; i < 4; i++) begin
        if (req[i] && !gnt4[i]) wait4[i]++; else wait4[i] = 0;
        if (wait4[i] > 3 * 4) begin
          miscompares++;
          $display("FAIL starve4 src=%0d waited %0d cycles, limit 12", i, wait4[i]);
          wait4[i] = 0;
        end
      end
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      check("hold1", e, gnt1, sel1_1, sel2_1, busy1, y1);
      for (int i = 0; i < 4; i++) begin
        if (req[i] && !gnt1[i]) wait1[i]++; else wait1[i] = 0;
        if (wait1[i] > 3) begin
          miscompares++;
          $display("FAIL starve1 src=%0d waited %0d cycles, limit 3", i, wait1[i]);
          wait1[i] = 0;
        end
      end
    end
  end

  task automatic drive(input logic [3:0] r);
    exp_t e;
    @(negedge clk);
    req = r;
    a = 8'($urandom);
    b = 8'($urandom);
    c = 8'($urandom);
    d = 8'($urandom);
    model_step(0, r, e);
    q4.push_back(e);
    model_step(1, r, e);
    q1.push_back(e);
  endtask

  task automatic check_reset_outputs(input string name);
    exp_t z;
    z = '0;
    check({name, "_h4"}, z, gnt4, sel1_4, sel2_4, busy4, y4);
    check({name, "_h1"}, z, gnt1, sel1_1, sel2_1, busy1, y1);
  endtask

  // Assert reset between edges and confirm outputs drop before any clock edge.
  task automatic reset_mid_cycle();
    @(posedge clk);
    #3;
    rst = 1'b1;
    req = 4'b0000;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] r;
    hold_of[0] = 4;
    hold_of[1] = 1;
    model_reset();
    #1;
    check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    repeat (20) drive(4'b1111);
    repeat (2)  drive(4'b0000);
    repeat (10) drive(4'b0100);
    repeat (2)  drive(4'b0000);
    repeat (2)  drive(4'b0010);
    repeat (3)  drive(4'b1001);
    drive(4'b0000);
    repeat (2)  drive(4'b1000);
    reset_mid_cycle();
    repeat (3)  drive(4'b1111);
    drive(4'b0000);
    repeat (10) drive(4'b0101);
    drive(4'b0000);

    r = 4'b0000;
    for (int n = 0; n < 10000; n++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 7) == 0) r[i] = ~r[i];
      end
      drive(r);
    end
    repeat (2) drive(4'b0000);
    repeat (3) @(posedge clk);
    #2;

    vectors++;
    if (q4.size() != 0 || q1.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d/%0d expectations left, expected 0/0", q4.size(), q1.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mux4_rr_arbiter.md
MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

Interface
REQ-001 Parameter: HOLD_CYCLES, default 4, maximum consecutive cycles one requester owns the mux while others wait; legal range 1..15.
REQ-002 Parameter: DW, default 1, data width of each mux input and of y.
REQ-003 The block SHALL have exactly one clock; reset is asynchronous and active-high.
REQ-004 Port: clk  input  1  rising-edge clock.
REQ-005 Port: rst  input  1  asynchronous active-high reset.
REQ-006 Port: req  input  4  request per source; bit i belongs to source i; level-held by the requester.
REQ-007 Port: a, b, c, d  input  DW each  data of sources 0, 1, 2, 3.
REQ-008 Port: gnt  output  4  one-hot grant, registered.
REQ-009 Port: sel1  output  1  mux select LSB, registered; equals granted index bit 0.
REQ-010 Port: sel2  output  1  mux select MSB, registered; equals granted index bit 1.
REQ-011 Port: busy  output  1  high while any grant is active, registered.
REQ-012 Port: y  output  DW  selected data: a/b/c/d for {sel2,sel1} = 00/01/10/11 when busy; all zeros when idle.

Function
REQ-013 The FSM SHALL have two states: IDLE (no grant) and BUSY (one grant active).
REQ-014 The internal priority pointer ptr (2 bits) SHALL name the highest-priority source; search order ptr, ptr+1, ptr+2, ptr+3 mod 4.
REQ-015 All state changes SHALL occur on the rising clk edge; req is sampled at that edge, and gnt/sel/busy reflect the decision one cycle later.
REQ-016 IDLE with req != 0: grant the first requesting source in search order, go BUSY, clear the hold counter cnt, and set ptr = granted index + 1 mod 4 (3 wraps to 0).
REQ-017 IDLE with req == 0: remain IDLE; gnt = 0; sel1/sel2 hold their last values.
REQ-018 BUSY with req[cur] = 0 (release) and other requests pending: switch in the same edge to the next requester in search order from ptr; no idle cycle between grants.
REQ-019 BUSY with req[cur] = 0 and no other requests: go IDLE; gnt = 0 and busy = 0 on the next cycle.
REQ-020 BUSY with req[cur] = 1, cnt = HOLD_CYCLES-1 and another source requesting: preempt and switch to the next requester in search order; cnt cleared.
REQ-021 BUSY with req[cur] = 1, cnt = HOLD_CYCLES-1 and no other request: keep the grant and clear cnt to 0.
REQ-022 Otherwise in BUSY: keep the grant and increment cnt (4-bit, never exceeds HOLD_CYCLES-1).
REQ-023 gnt SHALL never have more than one bit set; {sel2,sel1} SHALL always equal the index of the set gnt bit while busy.
REQ-024 HOLD_CYCLES = 1: with several continuous requesters, the grant rotates every cycle.
REQ-025 y SHALL be combinational from the registered sel and busy and the data inputs; it adds no extra latency.

Reset
REQ-026 While rst = 1, regardless of clk: state = IDLE, gnt = 0000, sel1 = 0, sel2 = 0, busy = 0, ptr = 0, cnt = 0, y = 0.
REQ-027 Reset asserted mid-grant SHALL drop the grant immediately (asynchronously), not at the next edge.
REQ-028 After rst deasserts, the first arbitration SHALL use ptr = 0, so source 0 has top priority.

Verification
REQ-029 Reset then req = 1111 held, HOLD_CYCLES = 4 -> gnt = 0001 for 4 cycles, then 0010, 0100, 1000 for 4 cycles each, then back to 0001; sel follows 00, 01, 10, 11.
REQ-030 req = 0100 alone for 10 cycles -> gnt = 0100 and sel = 10 for all 10 cycles, no preemption; y = c; then req = 0000 -> gnt = 0000, busy = 0 and y = 0 the next cycle.
REQ-031 Source 1 granted, req changes 0010 -> 1001 at the same edge -> next grant is source 3 (ptr = 2, search order 2, 3, 0, 1), with no idle cycle.
REQ-032 rst pulsed while gnt = 1000 -> gnt = 0000 and sel = 00 before the next clk edge; the next req = 1111 grants source 0.
REQ-033 HOLD_CYCLES = 1, req = 0101 held -> gnt alternates 0001, 0100 every cycle; y alternates a, c.
REQ-034 A random req stream of at least 10k cycles -> a checker confirms gnt is one-hot or zero, sel matches gnt, no waiting requester is skipped for more than 3 × HOLD_CYCLES cycles, and y equals the selected input.
